// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams 64-bit word pairs LSW first through one
// addition64 instance, chaining the carry across cycles. Optional macro: MPADD_ZERO_FLAG_EN.

module addition64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        carry_in,
   output logic [63:0] sum,
   output logic        carry_out
);
   logic [63:0] g;
   logic [63:0] p;
   logic [64:0] c;
   logic [15:0] grp_g;
   logic [15:0] grp_p;
   logic [16:0] grp_c;

   // Two-level lookahead: 4-bit groups with group generate/propagate chained across groups.
   always_comb begin
      g     = a & b;
      p     = a ^ b;
      c     = '0;
      grp_g = '0;
      grp_p = '0;
      grp_c = '0;
      grp_c[0] = carry_in;
      for (int k = 0; k < 16; k++) begin
         grp_g[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p[k] = &p[4*k +: 4];
         grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
         c[4*k]   = grp_c[k];
         c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
      end
      c[64]     = grp_c[16];
      sum       = p ^ c[63:0];
      carry_out = c[64];
   end
endmodule

module mp_add_sequencer #(
   parameter int MAX_WORDS = 16,
   parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_sub,
   input  logic [CNT_W-1:0] cmd_words,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      a_word,
   input  logic [63:0]      b_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      sum_word,
   output logic             out_last,
   output logic             carry_final,
   output logic             zero_flag,
   output logic             err,
   output logic             busy
);
   // Handshakes: a transfer occurs on a rising edge where valid and ready are both 1;
   // a producer holds valid and data stable until that edge.
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             sub_r;
   logic [CNT_W-1:0] len_r;
   logic [CNT_W-1:0] idx_r;
   logic             carry_r;
   logic [63:0]      sum_r;
   logic             out_valid_r;
   logic             out_last_r;
   logic             carry_final_r;
   logic             err_r;

   logic             cmd_acc;
   logic             in_acc;
   logic             out_acc;
   logic             is_last;
   logic             cmd_zero;
   logic             cmd_over;
   logic [63:0]      add_b;
   logic             add_cin;
   logic [63:0]      add_sum;
   logic             add_cout;

   assign cmd_ready = (state == IDLE);
   assign in_ready  = (state == RUN) && (!out_valid_r || out_ready);
   assign busy      = (state != IDLE);
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign in_acc    = in_valid && in_ready;
   assign out_acc   = out_valid_r && out_ready;
   assign is_last   = (idx_r == len_r - CNT_W'(1));
   assign cmd_zero  = (cmd_words == '0);
   assign cmd_over  = (cmd_words > CNT_W'(MAX_WORDS));

   // Subtraction is A + ~B + 1; the +1 enters as carry-in of the first word only.
   assign add_b   = sub_r ? ~b_word : b_word;
   assign add_cin = (idx_r == '0) ? sub_r : carry_r;

   addition64 u_add (
      .a         (a_word),
      .b         (add_b),
      .carry_in  (add_cin),
      .sum       (add_sum),
      .carry_out (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_acc && !cmd_zero) state_nxt = RUN;
         RUN:     if (in_acc && is_last)    state_nxt = DRAIN;
         DRAIN:   if (out_ready)            state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_r         <= 1'b0;
         len_r         <= '0;
         idx_r         <= '0;
         carry_r       <= 1'b0;
         sum_r         <= '0;
         out_valid_r   <= 1'b0;
         out_last_r    <= 1'b0;
         carry_final_r <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         err_r <= cmd_acc && (cmd_zero || cmd_over);
         if (cmd_acc && !cmd_zero) begin
            sub_r <= cmd_sub;
            len_r <= cmd_over ? CNT_W'(MAX_WORDS) : cmd_words;
            idx_r <= '0;
         end
         // An input accept refills the output register even while its old word drains.
         if (in_acc) begin
            sum_r         <= add_sum;
            carry_r       <= add_cout;
            out_valid_r   <= 1'b1;
            out_last_r    <= is_last;
            carry_final_r <= is_last && add_cout;
            idx_r         <= idx_r + CNT_W'(1);
         end else if (out_acc) begin
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            carry_final_r <= 1'b0;
         end
      end
   end

`ifdef MPADD_ZERO_FLAG_EN
   logic nonzero_r;
   logic zero_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nonzero_r <= 1'b0;
         zero_r    <= 1'b0;
      end else if (state == IDLE || (state == DRAIN && out_ready)) begin
         nonzero_r <= 1'b0;
         zero_r    <= 1'b0;
      end else if (in_acc) begin
         nonzero_r <= nonzero_r | (|add_sum);
         zero_r    <= is_last && !(nonzero_r | (|add_sum));
      end
   end

   assign zero_flag = zero_r;
`else
   assign zero_flag = 1'b0;
`endif

   assign out_valid   = out_valid_r;
   assign sum_word    = sum_r;
   assign out_last    = out_last_r;
   assign carry_final = carry_final_r;
   assign err         = err_r;
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer: directed and random operations compared against a
// whole-number reference model (wide integer add/subtract modulo 2^(64*n)).

module tb_mp_add_sequencer;
   localparam int MAXW = 16;
   localparam int CW   = 5;

`ifdef MPADD_ZERO_FLAG_EN
   localparam bit ZF_EN = 1'b1;
`else
   localparam bit ZF_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_sub;
   logic [CW-1:0] cmd_words;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   a_word;
   logic [63:0]   b_word;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   sum_word;
   logic          out_last;
   logic          carry_final;
   logic          zero_flag;
   logic          err;
   logic          busy;

   int            total = 0;
   int            bad   = 0;
   logic [63:0]   exp_q[$];

   mp_add_sequencer #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_sub     (cmd_sub),
      .cmd_words   (cmd_words),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a_word      (a_word),
      .b_word      (b_word),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sum_word    (sum_word),
      .out_last    (out_last),
      .carry_final (carry_final),
      .zero_flag   (zero_flag),
      .err         (err),
      .busy        (busy)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [1023:0] rand_big();
      logic [1023:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Reference: treat operands as n*64-bit integers.
   function automatic void ref_model(input bit sub, input int n, input logic [1023:0] a_big,
                                     input logic [1023:0] b_big, output logic [63:0] w[MAXW],
                                     output bit cf, output bit allz);
      logic [1024:0] one;
      logic [1024:0] mask;
      logic [1024:0] am;
      logic [1024:0] bm;
      logic [1024:0] r;
      one  = 1;
      mask = (one << (64 * n)) - one;
      am   = {1'b0, a_big} & mask;
      bm   = {1'b0, b_big} & mask;
      if (!sub) begin
         r  = am + bm;
         cf = r[64 * n];
      end else begin
         r  = am - bm;
         cf = (am >= bm);
      end
      r = r & mask;
      for (int i = 0; i < MAXW; i++) w[i] = (i < n) ? r[64*i +: 64] : 64'h0;
      allz = (r == 0);
   endfunction

   // Driver + scoreboard for one full operation; returns at a negedge after the last beat.
   task automatic run_op(input bit sub, input logic [CW-1:0] words, input logic [1023:0] a_big,
                         input logic [1023:0] b_big, input int stall_pct, input int hold_word,
                         input int hold_len);
      logic [63:0] w[MAXW];
      bit          cf;
      bit          allz;
      int          n;
      int          idx;
      int          oidx;
      int          beats;
      int          cyc;
      int          held;
      bit          prev_in;
      bit          lastw;
      n = (int'(words) > MAXW) ? MAXW : int'(words);
      ref_model(sub, n, a_big, b_big, w, cf, allz);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(w[i]);

      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_sub   = sub;
      cmd_words = words;
      #1;
      check("cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("busy_run", busy, 1);
      check("err_on_cmd", err, (int'(words) > MAXW) ? 1 : 0);

      idx = 0; oidx = 0; beats = 0; cyc = 0; held = 0; prev_in = 0;
      while (oidx < n && cyc < 3000) begin
         if (prev_in) check("latency_1", out_valid, 1);
         in_valid = (idx < n) && ($urandom_range(0, 99) >= 15);
         if (idx < n) begin
            a_word = a_big[64*idx +: 64];
            b_word = b_big[64*idx +: 64];
         end
         if (out_valid && oidx == hold_word && held < hold_len) begin
            out_ready = 1'b0;
            held++;
         end else begin
            out_ready = ($urandom_range(0, 99) >= stall_pct);
         end
         #1;
         if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
         if (out_valid) begin
            lastw = (oidx == n - 1);
            check("sum_word", sum_word, exp_q[0]);
            check("out_last", out_last, lastw);
            check("zero_flag", zero_flag, ZF_EN && lastw && allz);
            if (lastw) check("carry_final", carry_final, cf);
            if (out_ready) begin
               void'(exp_q.pop_front());
               oidx++;
               beats++;
            end
         end
         prev_in = in_valid && in_ready;
         if (prev_in) idx++;
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("op_timeout_words", oidx, n);
      check("beats", beats, n);
      check("idle_out_valid", out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      logic [1023:0] a_big;
      logic [1023:0] b_big;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_sub   = 1'b0;
      cmd_words = '0;
      in_valid  = 1'b0;
      a_word    = '0;
      b_word    = '0;
      out_ready = 1'b0;
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_sum", sum_word, 0);
      check("rst_last", out_last, 0);
      check("rst_cf", carry_final, 0);
      check("rst_zf", zero_flag, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1-word add with carry out
      a_big = '0; b_big = '0;
      a_big[63:0] = 64'hFFFF_FFFF_FFFF_FFFF; b_big[63:0] = 64'h1;
      run_op(1'b0, CW'(1), a_big, b_big, 0, -1, 0);

      // 2-word add, carry chains into the upper word
      run_op(1'b0, CW'(2), a_big, b_big, 0, -1, 0);

      // 1-word subtract with and without borrow
      a_big = '0; b_big = '0;
      a_big[63:0] = 64'd5; b_big[63:0] = 64'd7;
      run_op(1'b1, CW'(1), a_big, b_big, 0, -1, 0);
      a_big[63:0] = 64'd7; b_big[63:0] = 64'd5;
      run_op(1'b1, CW'(1), a_big, b_big, 0, -1, 0);

      // 4-word add with a 3-cycle sink stall on word 1
      run_op(1'b0, CW'(4), rand_big(), rand_big(), 0, 1, 3);

      // Illegal zero-length command
      @(negedge clk);
      cmd_valid = 1'b1; cmd_words = '0; cmd_sub = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("err_zero_pulse", err, 1);
      check("err_zero_busy", busy, 0);
      check("err_zero_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      check("err_zero_clear", err, 0);
      check("err_zero_no_out", out_valid, 0);

      // Oversized length is clamped to MAXW
      run_op(1'b1, CW'(20), rand_big(), rand_big(), 25, -1, 0);

      // Mid-operation reset
      @(negedge clk);
      cmd_valid = 1'b1; cmd_sub = 1'b0; cmd_words = CW'(4);
      @(negedge clk);
      cmd_valid = 1'b0;
      in_valid  = 1'b1; a_word = 64'hFFFF_FFFF_FFFF_FFFF; b_word = 64'h1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_last", out_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, CW'(1), rand_big(), rand_big(), 0, -1, 0);

      // Equal operands subtract to zero with no borrow
      a_big = rand_big();
      run_op(1'b1, CW'(3), a_big, a_big, 20, -1, 0);

      // Random operations with random source/sink pacing
      for (int t = 0; t < 10; t++) begin
         run_op(1'($urandom_range(0, 1)), CW'($urandom_range(1, MAXW)), rand_big(), rand_big(),
                $urandom_range(0, 50), -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
- Multi-precision add/subtract controller built on the existing 64-bit carry-lookahead adder `addition64`.
- Accepts an operation command, then streams operand word pairs, least significant word first.
- Uses one `addition64` instance for every word and chains the carry across cycles.
- Sits between a big-integer operand source and its result sink; used for arithmetic wider than 64 bits.

Parameters:
- MAX_WORDS, 16, maximum operand length in 64-bit words.
- CNT_W, $clog2(MAX_WORDS+1), width of the word-count fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are 1.
- cmd_sub  in  1  0 = A+B, 1 = A−B.
- cmd_words  in  CNT_W  operand length in words.
- in_valid  in  1  operand word pair offered.
- in_ready  out  1  operand word pair accepted when both are 1.
- a_word  in  64  operand A word.
- b_word  in  64  operand B word.
- out_valid  out  1  result word valid.
- out_ready  in  1  sink accepts result word.
- sum_word  out  64  result word.
- out_last  out  1  marks the final result word.
- carry_final  out  1  final carry out (for subtraction, 1 = no borrow); valid only with out_last.
- zero_flag  out  1  see Optional Feature.
- err  out  1  one-cycle pulse on an illegal command.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
Reset:
- rst_n low forces state IDLE.
- All outputs go to 0 except cmd_ready = 1.
- Word counter, carry register and output register are cleared.
- Reset takes effect asynchronously at any point, including mid-operation; the partial result is discarded and no out_last is produced.

State IDLE:
- cmd_ready = 1, in_ready = 0.
- On cmd accept with cmd_words = 0: err pulses high for 1 cycle and the state stays IDLE.
- On cmd accept with cmd_words > MAX_WORDS: length is clamped to MAX_WORDS and err pulses.
- Otherwise: latch cmd_sub and the length, set word index to 0, go to RUN.

State RUN:
- cmd_ready = 0.
- in_ready = !out_valid || out_ready (single-stage output register; full throughput when the sink does not stall).
- Adder inputs per word:
  - a = a_word.
  - b = cmd_sub ? ~b_word : b_word.
  - carry_in = (index == 0) ? cmd_sub : carry register.
- On input accept:
  - Registered sum_word = adder sum.
  - carry register = adder carry_out.
  - out_valid set to 1; index increments.
  - If index = length−1: out_last = 1, carry_final = adder carry_out, go to DRAIN.
- Latency: a result word is visible 1 cycle after its input accept.

State DRAIN:
- in_ready = 0.
- Hold sum_word, out_last and carry_final stable until out_ready is high.
- Then clear out_valid, out_last and carry_final, and go to IDLE.
- cmd_ready rises the following cycle; there is no same-cycle cmd accept in DRAIN.

Output handshake:
- When out_valid is high and out_ready is low, sum_word, out_last and carry_final must not change.
- A simultaneous output accept and input accept in RUN replaces the register contents in the same cycle (no bubble).

Width rules:
- All arithmetic is modulo 2^64 per word.
- The carry register is 1 bit; no sign extension.

Optional Feature:
- Macro: MPADD_ZERO_FLAG_EN.
- Defined:
  - A sticky register ORs every result word during the operation.
  - zero_flag = 1 with out_last when all result words were zero, else 0.
  - zero_flag clears on return to IDLE and on reset.
- Undefined: zero_flag is tied to 0 and no extra logic is present.

Test Plan:
1. cmd_words=1, add, a=0xFFFFFFFFFFFFFFFF, b=0x1 -> one cycle later sum_word=0x0, out_last=1, carry_final=1.
2. cmd_words=2, add, A={hi 0x0, lo 0xFFFFFFFFFFFFFFFF}, B={hi 0x0, lo 0x1} -> words 0x0 then 0x1, carry_final=0, out_last only on the second word.
3. cmd_words=1, sub, a=5, b=7 -> sum_word=0xFFFFFFFFFFFFFFFE, carry_final=0 (borrow); repeat with a=7, b=5 -> sum_word=0x2, carry_final=1.
4. cmd_words=4 add with out_ready held low 3 cycles after word 1 -> in_ready low during the stall, sum_word stable, all 4 words delivered in order, total output beats = 4.
5. rst_n pulled low after word 1 of 4 is accepted -> out_valid=0, busy=0, cmd_ready=1 immediately; a new 1-word command afterwards computes correctly with carry_in unaffected.
6. cmd_words=0 -> err pulses high for 1 cycle, no out_valid, stays IDLE. With MPADD_ZERO_FLAG_EN, a 3-word sub with A=B -> zero_flag=1 and carry_final=1 on the last word.
